ucsbece154b_gshare_predictor: RTL and testbench
===============================================

Name: ucsbece154b_gshare_predictor

Overview:
Fetch-stage branch predictor that feeds the pipelined core's next-PC selection. It combines a direct-mapped branch target buffer (BTB) with a gshare pattern history table (PHT): 2-bit counters indexed by PC XOR global history register (GHR). It predicts combinationally in F from PCF and is trained from branches and jumps resolved in E. The core carries PHTIdxF_o down the pipe and returns it as PHTIdxE_i, and redirects on mispredicts.

Parameters:
NUM_BTB_ENTRIES, 32, BTB entries (power of 2); index = PC[log2(N)+1:2], tag = PC[31:log2(N)+2]
NUM_GHR_BITS, 5, GHR width; PHT holds 2^NUM_GHR_BITS 2-bit counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
PCF_i  input  32  fetch PC
PredTakenF_o  output  1  prediction: redirect fetch
PredPCF_o  output  32  predicted next PC
PHTIdxF_o  output  NUM_GHR_BITS  PHT index used for this prediction
UpdateE_i  input  1  resolved control-flow instruction in E, not flushed
IsBranchE_i  input  1  E instruction is a conditional branch
IsJumpE_i  input  1  E instruction is jal/jalr
PCE_i  input  32  PC of the E instruction
TargetE_i  input  32  resolved target
ActualTakenE_i  input  1  branch outcome (ignored for jumps)
PHTIdxE_i  input  NUM_GHR_BITS  PHTIdxF_o carried from F

Behaviour:
- State:
  - BTB entry = {valid, is_jump, tag, target[31:0]}.
  - PHT = 2^NUM_GHR_BITS 2-bit saturating counters.
  - GHR = NUM_GHR_BITS bits.
- Reset (reset==0, asynchronous, takes effect immediately, including mid-operation):
  - all BTB valid = 0; all PHT counters = 2'b01 (weakly not-taken); GHR = 0.
  - Outputs settle to PredTakenF_o=0 and PredPCF_o=PCF_i+4.
- Prediction (combinational, zero latency):
  - PHTIdxF_o = PCF_i[NUM_GHR_BITS+1:2] XOR GHR.
  - hit = valid && tag match at the BTB index of PCF_i.
  - PredTakenF_o = hit && (is_jump || PHT[PHTIdxF_o][1]).
  - PredPCF_o = PredTakenF_o ? BTB target : PCF_i+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
- Update (rising clk edge, only when UpdateE_i=1):
  - BTB: if IsJumpE_i, or IsBranchE_i && ActualTakenE_i, write the entry at PCE_i's index: valid=1, tag, target=TargetE_i, is_jump=IsJumpE_i. This unconditionally overwrites any conflicting entry. A not-taken branch never allocates and never invalidates.
  - PHT (IsBranchE_i only): counter[PHTIdxE_i] increments, saturating at 3, if taken; decrements, saturating at 0, if not.
  - GHR (IsBranchE_i only): GHR <= {GHR[NUM_GHR_BITS-2:0], ActualTakenE_i}. History is non-speculative.
  - IsBranchE_i and IsJumpE_i both 1 is illegal; jump handling wins.
  - UpdateE_i=0: no state change.
- Same-cycle F read and E write to the same entry or counter: F sees the pre-edge value. The new value is visible from the next cycle.
- The predictor never stalls. Stall and flush of the PC register are the core's responsibility.

Test Plan:
1. Release reset, PCF_i=0x100 -> PredTakenF_o=0, PredPCF_o=0x104, PHTIdxF_o=0x00.
2. Update jal: PCE=0x100, TargetE=0x200, IsJump=1. Next cycle PCF_i=0x100 -> PredTakenF_o=1, PredPCF_o=0x200. PCF_i=0x180 (same index, tag mismatch) -> PredTakenF_o=0, PredPCF_o=0x184.
3. Gshare indexing:
   - From reset, update a taken branch: PCE=0x40, TargetE=0x20, PHTIdxE=16 -> counter[16]=2'b10, GHR=5'b00001.
   - Then PCF_i=0x40 -> PHTIdxF_o=17, counter[17]=01, BTB hits -> PredTakenF_o=0, PredPCF_o=0x44.
4. Saturation:
   - Four taken branch updates at PHTIdxE=5 -> counter[5]=2'b11.
   - One not-taken update -> 2'b10, still predicts taken.
   - Three more not-taken updates -> 2'b00 and stays 00.
5. Same-cycle read and write: PCF_i=0x100 while the jal of test 2 updates -> PredTakenF_o=0 that cycle, 1 the next.
6. Drive reset=0 mid-stream, between clock edges, after tests 2-4 -> PredTakenF_o=0 immediately. After release, PCF_i=0x100 -> PredPCF_o=0x104 and all counters read 01.

Source files
------------

// File: rtl/ucsbece154b_gshare_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus gshare PHT of 2-bit counters.
// Predicts combinationally from PCF_i; trained non-speculatively from branches/jumps resolved in E.
module ucsbece154b_gshare_predictor #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             PCF_i,
  output logic                    PredTakenF_o,
  output logic [31:0]             PredPCF_o,
  output logic [NUM_GHR_BITS-1:0] PHTIdxF_o,
  input  logic                    UpdateE_i,
  input  logic                    IsBranchE_i,
  input  logic                    IsJumpE_i,
  input  logic [31:0]             PCE_i,
  input  logic [31:0]             TargetE_i,
  input  logic                    ActualTakenE_i,
  input  logic [NUM_GHR_BITS-1:0] PHTIdxE_i
);

  localparam int IDX_W = $clog2(NUM_BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int PHT_N = 1 << NUM_GHR_BITS;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    if (up) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

  logic [NUM_BTB_ENTRIES-1:0] r_btb_valid;
  logic [NUM_BTB_ENTRIES-1:0] r_btb_jump;
  logic [TAG_W-1:0]           r_btb_tag    [NUM_BTB_ENTRIES];
  logic [31:0]                r_btb_target [NUM_BTB_ENTRIES];
  logic [1:0]                 r_pht        [PHT_N];
  logic [NUM_GHR_BITS-1:0]    r_ghr;

  logic [IDX_W-1:0]        w_f_idx;
  logic [TAG_W-1:0]        w_f_tag;
  logic [NUM_GHR_BITS-1:0] w_f_pht_idx;
  logic                    w_f_hit;
  logic                    w_f_taken;
  logic [31:0]             w_f_pc_plus4;
  logic [31:0]             w_f_pred_pc;

  logic [IDX_W-1:0]        w_e_idx;
  logic [TAG_W-1:0]        w_e_tag;
  logic                    w_btb_we;
  logic                    w_br_upd;
  logic                    w_unused_pce_lsb;

  // Fetch-side prediction; reads only pre-edge state so same-cycle writes are not forwarded
  always_comb begin
    w_f_idx      = PCF_i[IDX_W+1:2];
    w_f_tag      = PCF_i[31:IDX_W+2];
    w_f_pht_idx  = PCF_i[NUM_GHR_BITS+1:2] ^ r_ghr;
    w_f_hit      = r_btb_valid[w_f_idx] && (r_btb_tag[w_f_idx] == w_f_tag);
    w_f_taken    = w_f_hit && (r_btb_jump[w_f_idx] || r_pht[w_f_pht_idx][1]);
    w_f_pc_plus4 = PCF_i + 32'd4;
    if (w_f_taken) begin
      w_f_pred_pc = r_btb_target[w_f_idx];
    end else begin
      w_f_pred_pc = w_f_pc_plus4;
    end
  end

  assign PredTakenF_o = w_f_taken;
  assign PredPCF_o    = w_f_pred_pc;
  assign PHTIdxF_o    = w_f_pht_idx;

  // Execute-side training controls; a jump flagged as branch too is handled purely as a jump
  always_comb begin
    w_e_idx  = PCE_i[IDX_W+1:2];
    w_e_tag  = PCE_i[31:IDX_W+2];
    w_btb_we = UpdateE_i && (IsJumpE_i || (IsBranchE_i && ActualTakenE_i));
    w_br_upd = UpdateE_i && IsBranchE_i && !IsJumpE_i;
  end

  assign w_unused_pce_lsb = ^PCE_i[1:0];

  // BTB allocation: taken control flow overwrites whatever lives at the index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
        r_btb_valid[i]  <= 1'b0;
        r_btb_jump[i]   <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= 32'd0;
      end
    end else if (w_btb_we) begin
      r_btb_valid[w_e_idx]  <= 1'b1;
      r_btb_jump[w_e_idx]   <= IsJumpE_i;
      r_btb_tag[w_e_idx]    <= w_e_tag;
      r_btb_target[w_e_idx] <= TargetE_i;
    end else begin
      r_btb_valid <= r_btb_valid;
    end
  end

  // PHT counters start weakly not-taken and train at the index F used for this branch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_N; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (w_br_upd) begin
      r_pht[PHTIdxE_i] <= sat_update(r_pht[PHTIdxE_i], ActualTakenE_i);
    end else begin
      r_pht[PHTIdxE_i] <= r_pht[PHTIdxE_i];
    end
  end

  // Global history shifts in resolved outcomes only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr <= '0;
    end else if (w_br_upd) begin
      r_ghr <= {r_ghr[NUM_GHR_BITS-2:0], ActualTakenE_i};
    end else begin
      r_ghr <= r_ghr;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_gshare_predictor.sv
// Self-checking bench for the gshare predictor: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based reference model.
module tb_ucsbece154b_gshare_predictor;

  localparam int NB = 32;
  localparam int G  = 5;
  localparam int NP = 1 << G;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pcf;
  logic          pred_taken;
  logic [31:0]   pred_pc;
  logic [G-1:0]  pht_idx_f;
  logic          upd, is_br, is_jmp, act_taken;
  logic [31:0]   pce, tgt;
  logic [G-1:0]  pht_idx_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_v   [NB];
  bit          m_j   [NB];
  int unsigned m_tag [NB];
  logic [31:0] m_tgt [NB];
  int          m_pht [NP];
  int          m_ghr;

  ucsbece154b_gshare_predictor #(.NUM_BTB_ENTRIES(NB), .NUM_GHR_BITS(G)) dut (
    .clk(clk), .reset(rst_n), .PCF_i(pcf),
    .PredTakenF_o(pred_taken), .PredPCF_o(pred_pc), .PHTIdxF_o(pht_idx_f),
    .UpdateE_i(upd), .IsBranchE_i(is_br), .IsJumpE_i(is_jmp), .PCE_i(pce),
    .TargetE_i(tgt), .ActualTakenE_i(act_taken), .PHTIdxE_i(pht_idx_e)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_v[i] = 1'b0; m_j[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0;
    end
    for (int i = 0; i < NP; i++) m_pht[i] = 1;
    m_ghr = 0;
  endfunction

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 4) % NB);
  endfunction

  function automatic int unsigned btag(input logic [31:0] pc);
    return int'(pc / (NB * 4));
  endfunction

  function automatic int pidx(input logic [31:0] pc);
    return (int'((pc / 4) % NP) ^ m_ghr) % NP;
  endfunction

  // Compare process: outputs must equal the model's prediction from current PCF and pre-edge state
  task automatic check_model();
    int  b, p;
    bit  hit, tk;
    logic [31:0] npc;
    b   = bidx(pcf);
    p   = pidx(pcf);
    hit = m_v[b] && (m_tag[b] == btag(pcf));
    tk  = hit && (m_j[b] || (m_pht[p] >= 2));
    npc = tk ? m_tgt[b] : pcf + 32'd4;
    chk("model_taken", {31'd0, pred_taken}, {31'd0, tk});
    chk("model_predpc", pred_pc, npc);
    chk("model_phtidx", {27'd0, pht_idx_f}, p);
  endtask

  function automatic void model_update();
    int b;
    if (!rst_n || !upd) return;
    if (is_jmp || (is_br && act_taken)) begin
      b = bidx(pce);
      m_v[b] = 1'b1; m_j[b] = is_jmp; m_tag[b] = btag(pce); m_tgt[b] = tgt;
    end
    if (is_br && !is_jmp) begin
      if (act_taken) m_pht[pht_idx_e] = (m_pht[pht_idx_e] == 3) ? 3 : m_pht[pht_idx_e] + 1;
      else           m_pht[pht_idx_e] = (m_pht[pht_idx_e] == 0) ? 0 : m_pht[pht_idx_e] - 1;
      m_ghr = ((m_ghr * 2) + (act_taken ? 1 : 0)) % NP;
    end
  endfunction

  task automatic step();
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_upd(input logic u, input logic b, input logic j, input logic [31:0] pc,
                         input logic [31:0] t, input logic a, input int pi);
    upd = u; is_br = b; is_jmp = j; pce = pc; tgt = t; act_taken = a; pht_idx_e = pi[G-1:0];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 63) == 0) return 32'hFFFF_FFFC;
    return 32'h1000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 31) << 2);
  endfunction

  int          exp_ctr [8];
  bit          exp_tk  [8];
  logic [31:0] q;
  bit          all_weak;
  int          r;

  initial begin
    exp_ctr = '{2, 3, 3, 3, 2, 1, 0, 0};
    exp_tk  = '{1, 1, 1, 1, 1, 0, 0, 0};
    rst_n = 1'b0;
    pcf   = 32'h100;
    set_upd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    pcf = 32'h100; #1;
    chk("t1_taken", {31'd0, pred_taken}, 32'd0);
    chk("t1_predpc", pred_pc, 32'h104);
    chk("t1_idx", {27'd0, pht_idx_f}, 32'd0);
    step();

    // jal allocation; F reads the same entry during the write and sees the old value
    set_upd(1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 0);
    pcf = 32'h100; #1;
    chk("t5_same_cycle_taken", {31'd0, pred_taken}, 32'd0);
    step();
    set_upd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    pcf = 32'h100; #1;
    chk("t2_hit_taken", {31'd0, pred_taken}, 32'd1);
    chk("t2_hit_predpc", pred_pc, 32'h200);
    step();
    pcf = 32'h180; #1;
    chk("t2_tagmiss_taken", {31'd0, pred_taken}, 32'd0);
    chk("t2_tagmiss_predpc", pred_pc, 32'h184);
    step();

    // Asynchronous reset between edges
    pcf = 32'h100; #1;
    chk("t6a_before_taken", {31'd0, pred_taken}, 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6a_async_taken", {31'd0, pred_taken}, 32'd0);
    chk("t6a_async_predpc", pred_pc, 32'h104);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Gshare indexing
    do_reset();
    set_upd(1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 1'b1, 16);
    pcf = 32'h0; #1;
    step();
    chk("t3_model_ctr16", m_pht[16], 32'd2);
    chk("t3_model_ghr", m_ghr, 32'd1);
    set_upd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    pcf = 32'h40; #1;
    chk("t3_idx", {27'd0, pht_idx_f}, 32'd17);
    chk("t3_taken", {31'd0, pred_taken}, 32'd0);
    chk("t3_predpc", pred_pc, 32'h44);
    step();

    // Saturation on counter 5, observed through branch entries at every BTB index
    do_reset();
    for (int k = 0; k < NB; k++) begin
      set_upd(1'b1, 1'b1, 1'b0, 32'h1000 | (k << 2), 32'h2000 + k * 4, 1'b1, 0);
      pcf = 32'h1000 | (k << 2); #1;
      step();
    end
    chk("t4_model_ghr_full", m_ghr, 32'd31);
    for (int s = 0; s < 8; s++) begin
      set_upd(1'b1, 1'b1, 1'b0, 32'h1014, 32'h2014, (s < 4) ? 1'b1 : 1'b0, 5);
      pcf = 32'h100; #1;
      step();
      set_upd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0);
      q   = 32'h1000 | (((5 ^ m_ghr) % NP) << 2);
      pcf = q; #1;
      chk($sformatf("t4_model_ctr_s%0d", s), m_pht[5], exp_ctr[s]);
      chk($sformatf("t4_idx_s%0d", s), {27'd0, pht_idx_f}, 32'd5);
      chk($sformatf("t4_taken_s%0d", s), {31'd0, pred_taken}, {31'd0, exp_tk[s]});
      step();
    end

    // Mid-stream reset after training, then everything back to initial state
    set_upd(1'b1, 1'b0, 1'b1, 32'h3000, 32'h3300, 1'b0, 0);
    pcf = 32'h100; #1;
    step();
    set_upd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    pcf = 32'h3000; #1;
    chk("t6b_before_predpc", pred_pc, 32'h3300);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6b_async_taken", {31'd0, pred_taken}, 32'd0);
    chk("t6b_async_predpc", pred_pc, 32'h3004);
    #1 rst_n = 1'b1;
    @(negedge clk);
    pcf = 32'h100; #1;
    chk("t6b_after_predpc", pred_pc, 32'h104);
    all_weak = 1'b1;
    for (int i = 0; i < NP; i++) if (m_pht[i] != 1) all_weak = 1'b0;
    chk("t6b_model_all_weak", {31'd0, all_weak}, 32'd1);
    step();
    pcf = 32'h7C; #1;
    chk("t6b_idx_ghr_clear", {27'd0, pht_idx_f}, 32'd31);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pcf = rand_pc();
      r   = $urandom_range(0, 9);
      q   = rand_pc();
      if (r < 2) begin
        set_upd(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), q, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 1), $urandom_range(0, NP - 1));
      end else if (r < 4) begin
        set_upd(1'b1, 1'b0, 1'b1, q, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1), 0);
      end else begin
        set_upd(1'b1, 1'b1, 1'b0, q, 32'h4000 + ($urandom_range(0, 255) << 2),
                $urandom_range(0, 2) != 0, ($urandom_range(0, 1) != 0) ? pidx(q) : $urandom_range(0, NP - 1));
      end
      #1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
